// File: rtl/btn_pkg.sv
// Shared constants, index type and encoder helpers for the button front end.
package btn_pkg;

  localparam int N_BTN                   = 4;
  localparam int BTN_IDX_W               = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef logic [BTN_IDX_W-1:0] btn_idx_t;

  // Lowest-index set bit wins; an empty vector encodes as 0.
  function automatic btn_idx_t lowest_set(input logic [N_BTN-1:0] vec);
    btn_idx_t idx;
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (vec[i]) idx = btn_idx_t'(i);
    end
    return idx;
  endfunction

  // True when clearing the lowest set bit still leaves a bit set.
  function automatic logic more_than_one(input logic [N_BTN-1:0] vec);
    return (vec & (vec - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchroniser, polarity normalisation and a
// stable-count debouncer. btn_state is the accepted level, 1 = pressed.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_state
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw level a released button presents on the pin.
  localparam logic            RELEASED_RAW = BTN_ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             sync_pressed;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sync_pressed = sync2_q ^ BTN_ACTIVE_LOW;
  assign btn_state    = state_q;

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_d = state_q;
    cnt_d   = '0;
    if (sync_pressed != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d = sync_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser stages, accepted level and counter; reset to released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so sync2_q takes the old sync1_q and the chain stays two stages deep.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Player pushbutton front end: per-button debounce, edge detect, priority
// encode, and a one-entry event register handed over with valid/ack.
// Optional macro BTN_RELEASE_EVENT_EN: releases also produce events, tagged
// by press_is_release.
module button_event_encoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             press_ack,
  output logic             press_valid,
  output btn_idx_t         press_id,
  output logic             press_multi,
  output logic             drop_sticky,
  output logic [N_BTN-1:0] btn_state
`ifdef BTN_RELEASE_EVENT_EN
  ,
  output logic             press_is_release
`endif
);

  logic [N_BTN-1:0] btn_prev_q;
  logic [N_BTN-1:0] rise_vec;
  logic [N_BTN-1:0] evt_vec;
  logic             rel_lost;
  logic             accept;

  logic     valid_q, valid_d;
  btn_idx_t id_q, id_d;
  logic     multi_q, multi_d;
  logic     drop_q, drop_d;

`ifdef BTN_RELEASE_EVENT_EN
  logic [N_BTN-1:0] fall_vec;
  logic             evt_is_rel;
  logic             rel_q, rel_d;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[i]),
      .btn_state(btn_state[i])
    );
  end

  // Pick this cycle's event source: presses always, releases only when enabled
  // and no press competes with them.
  always_comb begin
    rise_vec = btn_state & ~btn_prev_q;
`ifdef BTN_RELEASE_EVENT_EN
    fall_vec = ~btn_state & btn_prev_q;
    if (rise_vec != '0) begin
      evt_vec    = rise_vec;
      evt_is_rel = 1'b0;
      rel_lost   = fall_vec != '0;
    end else begin
      evt_vec    = fall_vec;
      evt_is_rel = 1'b1;
      rel_lost   = 1'b0;
    end
`else
    evt_vec  = rise_vec;
    rel_lost = 1'b0;
`endif
  end

  // Holding register: load when empty or being accepted, otherwise drop and flag.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    multi_d = multi_q;
    drop_d  = drop_q | rel_lost;
`ifdef BTN_RELEASE_EVENT_EN
    rel_d   = rel_q;
`endif
    accept  = valid_q & press_ack;
    if (evt_vec != '0) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        id_d    = lowest_set(evt_vec);
        multi_d = more_than_one(evt_vec);
`ifdef BTN_RELEASE_EVENT_EN
        rel_d   = evt_is_rel;
`endif
      end else begin
        drop_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Edge-detect history and event register; reset discards any pending event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_prev_q <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      multi_q    <= 1'b0;
      drop_q     <= 1'b0;
`ifdef BTN_RELEASE_EVENT_EN
      rel_q      <= 1'b0;
`endif
    end else begin
      btn_prev_q <= btn_state;
      valid_q    <= valid_d;
      id_q       <= id_d;
      multi_q    <= multi_d;
      drop_q     <= drop_d;
`ifdef BTN_RELEASE_EVENT_EN
      rel_q      <= rel_d;
`endif
    end
  end

  assign press_valid = valid_q;
  assign press_id    = id_q;
  assign press_multi = multi_q;
  assign drop_sticky = drop_q;
`ifdef BTN_RELEASE_EVENT_EN
  assign press_is_release = rel_q;
`endif

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder with DEBOUNCE_CYCLES=4, active-low
// buttons. A window-based reference model is compared on every cycle, and
// literal expectations pin the documented latencies and scenarios.
module tb_button_event_encoder;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'hF;
  logic       press_ack = 1'b0;

  logic       press_valid;
  logic [1:0] press_id;
  logic       press_multi;
  logic       drop_sticky;
  logic [3:0] btn_state;
`ifdef BTN_RELEASE_EVENT_EN
  logic       press_is_release;
`endif

  button_event_encoder #(
    .DEBOUNCE_CYCLES(DC),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .press_ack  (press_ack),
    .press_valid(press_valid),
    .press_id   (press_id),
    .press_multi(press_multi),
    .drop_sticky(drop_sticky),
    .btn_state  (btn_state)
`ifdef BTN_RELEASE_EVENT_EN
    ,
    .press_is_release(press_is_release)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pressed levels sampled at each edge; smp[k] is the sample from k edges ago.
  // A button's accepted level flips once the synchronised samples (which lag
  // the pin by two edges) have disagreed with it for DC edges in a row.
  logic [3:0] smp [0:DC+1];
  logic [3:0] m_state = '0, m_prev = '0, m_rise, m_next;
  logic       m_valid = 1'b0, m_multi = 1'b0, m_drop = 1'b0, m_all_diff;
  logic [1:0] m_id = '0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k <= DC + 1; k++) smp[k] = '0;
      m_state = '0;
      m_prev  = '0;
      m_valid = 1'b0;
      m_id    = '0;
      m_multi = 1'b0;
      m_drop  = 1'b0;
    end else begin
      m_rise = m_state & ~m_prev;
      if (m_rise != '0) begin
        if (!m_valid || press_ack) begin
          m_valid = 1'b1;
          m_multi = $countones(m_rise) > 1;
          for (int i = 3; i >= 0; i--) if (m_rise[i]) m_id = 2'(i);
        end else begin
          m_drop = 1'b1;
        end
      end else if (m_valid && press_ack) begin
        m_valid = 1'b0;
      end
      for (int k = DC + 1; k > 0; k--) smp[k] = smp[k-1];
      smp[0] = ~btn_raw;
      m_next = m_state;
      for (int b = 0; b < 4; b++) begin
        m_all_diff = 1'b1;
        for (int k = 2; k <= DC + 1; k++) if (smp[k][b] == m_state[b]) m_all_diff = 1'b0;
        if (m_all_diff) m_next[b] = ~m_state[b];
      end
      m_prev  = m_state;
      m_state = m_next;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_valid", press_valid, m_valid);
      check("cyc_id", press_id, m_id);
      check("cyc_multi", press_multi, m_multi);
      check("cyc_drop", drop_sticky, m_drop);
      check("cyc_state", btn_state, m_state);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_once();
    press_ack = 1'b1;
    tick(1);
    press_ack = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    tick(3);
    check("rst_valid", press_valid, 0);
    check("rst_id", press_id, 0);
    check("rst_multi", press_multi, 0);
    check("rst_drop", drop_sticky, 0);
    check("rst_state", btn_state, 0);
    cmp_en = 1'b1;
    rst = 1'b1;
    tick(2);

    // Single press of button 1, no ack.
    btn_raw = 4'b1101;
    tick(6);
    check("sp_valid_e6", press_valid, 0);
    check("sp_state_e6", btn_state, 4'b0010);
    tick(1);
    check("sp_valid_e7", press_valid, 1);
    check("sp_id_e7", press_id, 1);
    check("sp_multi_e7", press_multi, 0);
    tick(13);
    check("sp_valid_hold", press_valid, 1);
    check("sp_id_hold", press_id, 1);
    ack_once();
    check("sp_valid_acked", press_valid, 0);
    btn_raw = 4'hF;
    tick(10);
    check("sp_release_no_evt", press_valid, 0);
    check("sp_release_state", btn_state, 0);

    // Glitch on button 0 shorter than the debounce window.
    btn_raw[0] = 1'b0;
    tick(3);
    btn_raw[0] = 1'b1;
    tick(12);
    check("gl_state", btn_state, 0);
    check("gl_valid", press_valid, 0);

    // Buttons 0 and 3 pressed together.
    btn_raw = 4'b0110;
    tick(7);
    check("sim_valid", press_valid, 1);
    check("sim_id", press_id, 0);
    check("sim_multi", press_multi, 1);
    check("sim_drop", drop_sticky, 0);
    tick(5);
    ack_once();
    check("sim_one_evt", press_valid, 0);
    btn_raw = 4'hF;
    tick(10);
    check("sim_after_rel", press_valid, 0);

    // Back-to-back: button 2 held, ack exactly as button 3's edge arrives.
    btn_raw = 4'b1011;
    tick(7);
    check("b2b_first_id", press_id, 2);
    btn_raw = 4'b0011;
    tick(6);
    check("b2b_pre_valid", press_valid, 1);
    check("b2b_pre_id", press_id, 2);
    ack_once();
    check("b2b_valid", press_valid, 1);
    check("b2b_id", press_id, 3);
    check("b2b_drop", drop_sticky, 0);
    ack_once();
    check("b2b_cleared", press_valid, 0);
    btn_raw = 4'hF;
    tick(10);

    // Overflow: button 1 pending, button 2 pressed later without ack.
    btn_raw = 4'b1101;
    tick(7);
    check("ov_first_id", press_id, 1);
    btn_raw = 4'hF;
    tick(8);
    btn_raw = 4'b1011;
    tick(8);
    check("ov_valid", press_valid, 1);
    check("ov_id", press_id, 1);
    check("ov_drop", drop_sticky, 1);
    ack_once();
    check("ov_valid_acked", press_valid, 0);
    check("ov_drop_sticks", drop_sticky, 1);
    btn_raw = 4'hF;
    tick(10);

    // Reset in the middle of button 3's debounce count.
    btn_raw = 4'b0111;
    tick(4);
    check("rm_state_mid", btn_state, 0);
    rst = 1'b0;
    tick(2);
    check("rm_valid", press_valid, 0);
    check("rm_id", press_id, 0);
    check("rm_multi", press_multi, 0);
    check("rm_drop", drop_sticky, 0);
    check("rm_state", btn_state, 0);
    rst = 1'b1;
    tick(6);
    check("rm_valid_e6", press_valid, 0);
    check("rm_state_e6", btn_state, 4'b1000);
    tick(1);
    check("rm_valid_e7", press_valid, 1);
    check("rm_id_e7", press_id, 3);
    tick(3);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_encoder.md
Name: button_event_encoder

Overview:
- Input-side front end for the whack-a-mole game datapath.
- The game drives the four target lights; this block conditions the four raw player pushbuttons:
  - synchronise each button,
  - debounce each button,
  - edge-detect each button,
  - encode presses into a single 2-bit button-index event.
- Delivers one press event at a time to the hit checker over a valid/ack handshake, so each physical press is scored exactly once.

Parameters:
- N_BTN, 4, number of buttons; fixed at 4 to match the 2-bit light index.
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks needed to accept a level change (1 ms at 50 MHz).
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board KEYs); 0 = active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- btn_raw  in  4  asynchronous raw pushbutton levels
- press_ack  in  1  consumer accepts the current event
- press_valid  out  1  event pending
- press_id  out  2  index of the pressed button (0..3)
- press_multi  out  1  more than one new press was detected in the same cycle as this event
- drop_sticky  out  1  a press was lost because an event was pending; cleared only by reset
- btn_state  out  4  debounced pressed levels, 1 = pressed

Behaviour:
- Reset (rst == 0 at a clk edge):
  - press_valid, press_id, press_multi, drop_sticky = 0.
  - btn_state = 0 (all released); debounce counters = 0.
  - Synchroniser flops = released level.
  - Reset mid-operation discards any pending event and any in-progress count.
- Synchroniser: 2 flops per button. Polarity is normalised after the second flop: pressed = 1.
- Debounce, per button, with a counter of width clog2(DEBOUNCE_CYCLES):
  - If sync == btn_state, counter := 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: btn_state := sync, counter := 0.
  - Else: counter := counter + 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_state.
- New-press vector = btn_state rising edges, i.e. btn_state & ~btn_state_q.
- Latency: the first clk edge that samples a new raw level is edge 1. press_valid is high after edge DEBOUNCE_CYCLES+3.
- Encoding:
  - press_id = lowest-index set bit of the new-press vector.
  - press_multi = 1 if more than one bit is set.
  - Higher-index simultaneous presses are discarded and do not set drop_sticky.
- Handshake (1-entry holding register):
  - press_valid, press_id and press_multi stay stable until the cycle in which press_valid and press_ack are both 1.
  - Accept with no new press in that cycle: press_valid := 0 on the next edge.
  - Accept with a new press in the same cycle: the register loads the new event; press_valid stays 1.
  - New press while press_valid = 1 and press_ack = 0: the new press is dropped, drop_sticky := 1, and the held event is unchanged.
  - press_ack while press_valid = 0 is ignored.
- Releases produce no event unless the optional feature below is enabled.
- Holding a button produces exactly one event; there is no auto-repeat.

Optional Feature:
- Macro: BTN_RELEASE_EVENT_EN.
- Defined:
  - Falling edges of btn_state also produce events through the same encoder and handshake.
  - Extra output press_is_release (1 bit) is held with the event: 1 = release, 0 = press.
  - Press and release in the same cycle: press wins and the release is dropped, setting drop_sticky.
- Undefined: press_is_release does not exist; falling edges are ignored.

Decomposition:
- Package btn_pkg holds:
  - N_BTN and BTN_IDX_W = 2;
  - the default DEBOUNCE_CYCLES constant;
  - the btn_idx_t typedef (2-bit).
- One sub-module, btn_debounce: a single-button synchroniser plus debounce counter, instantiated N_BTN times.
- Edge detect, encoder and handshake register live in the top level.

Test Plan (all with DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Single press: btn_raw 4'b1111 -> 4'b1101, held 20 cycles, press_ack=0. Required: press_valid rises after edge 7 with press_id=1, press_multi=0, and stays high; btn_state=4'b0010.
- Glitch: btn_raw[0] low for 3 cycles, then high. Required: btn_state stays 0, press_valid never asserts.
- Simultaneous press: btn_raw 4'b1111 -> 4'b0110 in one cycle. Required: press_id=0, press_multi=1, one event only, drop_sticky=0.
- Back-to-back: hold button 2 pressed, ack in the cycle button 3's edge arrives. Required: press_valid stays 1, press_id changes 2 -> 3.
- Overflow: press button 1 (no ack), release, then press button 2. Required: press_id stays 1, drop_sticky=1; after ack, press_valid=0.
- Reset mid-count: rst=0 during the debounce count of button 3, then rst=1. Required: all outputs 0, no event; a press must then take the full 7 edges.
